// File: rtl/slave_bus_port_pkg.sv
// Shared types for the bit-serial slave port: FSM states, transaction mode encodings
// and the bit-counter sizing helper.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WPAR,
    WRITE,
    READ,
    RSEND
  } state_e;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // The counter must reach ADDR_WIDTH-1 and, with parity enabled, DATA_WIDTH.
  function automatic int cnt_width(input int aw, input int dw);
    int m;
    m = (aw > dw + 1) ? aw : dw + 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/slave_bus_port_if.sv
// Bit-serial bus between interconnect master and slave port.
// There is no read-data backpressure: the master must sample every svalid cycle.
interface slave_bus_port_if;

  logic mvalid;
  logic mwdata;
  logic mmode;
  logic sready;
  logic svalid;
  logic srdata;

  modport master (
    output mvalid, mwdata, mmode,
    input  sready, svalid, srdata
  );

  modport slave (
    input  mvalid, mwdata, mmode,
    output sready, svalid, srdata
  );

endinterface

// File: rtl/slave_bus_port_shreg.sv
// Right-shifting register with serial input at the MSB and a parallel load.
// Load has priority over shift; one cycle per operation, no backpressure.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             sin,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_dat,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_dat;
    end else if (shift_en) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/slave_bus_port.sv
// Deserialises bus transactions into single-cycle memory accesses and serialises read data back.
// Optional SLAVE_PORT_PARITY_EN adds an even-parity bit to write data and read responses.
module slave_bus_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  slave_bus_port_if.slave       bus,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef SLAVE_PORT_PARITY_EN
  ,
  output logic                  perr
`endif
);

  localparam int CW = cnt_width(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
`ifdef SLAVE_PORT_PARITY_EN
  localparam logic [CW-1:0] RSEND_LAST = CW'(DATA_WIDTH);
`else
  localparam logic [CW-1:0] RSEND_LAST = CW'(DATA_WIDTH - 1);
`endif

  state_e          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            mode;
  logic            mode_ld;
  logic            addr_shift;
  logic            data_shift;
  logic            rd_load;
  logic            rd_shift;
  logic            sready;
  logic            svalid;
  logic            send_bit;
  logic [DATA_WIDTH-1:0] rd_q;
  logic            rd_unused;
`ifdef SLAVE_PORT_PARITY_EN
  logic            perr_set;
  logic            rpar;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      mode <= MODE_READ;
    end else begin
      cnt <= cnt_nxt;
      if (mode_ld) begin
        mode <= bus.mmode;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mode_ld    = 1'b0;
    addr_shift = 1'b0;
    data_shift = 1'b0;
    rd_load    = 1'b0;
    rd_shift   = 1'b0;
    sready     = 1'b0;
    svalid     = 1'b0;
    mem_wen    = 1'b0;
    mem_ren    = 1'b0;
`ifdef SLAVE_PORT_PARITY_EN
    perr_set   = 1'b0;
`endif
    case (state)
      IDLE: begin
        sready = 1'b1;
        if (bus.mvalid) begin
          mode_ld    = 1'b1;
          addr_shift = 1'b1;
          cnt_nxt    = CW'(1);
          state_nxt  = ADDR;
        end
      end
      ADDR: begin
        if (bus.mvalid) begin
          addr_shift = 1'b1;
          if (cnt == ADDR_LAST) begin
            cnt_nxt   = '0;
            state_nxt = (mode == MODE_WRITE) ? WDATA : READ;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      WDATA: begin
        if (bus.mvalid) begin
          data_shift = 1'b1;
          if (cnt == DATA_LAST) begin
            cnt_nxt = '0;
`ifdef SLAVE_PORT_PARITY_EN
            state_nxt = WPAR;
`else
            state_nxt = WRITE;
`endif
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      WPAR: begin
`ifdef SLAVE_PORT_PARITY_EN
        if (bus.mvalid) begin
          if (bus.mwdata == ^mem_wdata) begin
            state_nxt = WRITE;
          end else begin
            perr_set  = 1'b1;
            state_nxt = IDLE;
          end
        end
`else
        state_nxt = IDLE;
`endif
      end
      WRITE: begin
        mem_wen   = 1'b1;
        state_nxt = IDLE;
      end
      READ: begin
        mem_ren   = 1'b1;
        rd_load   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = RSEND;
      end
      RSEND: begin
        svalid   = 1'b1;
        rd_shift = 1'b1;
        if (cnt == RSEND_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  serial_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (addr_shift),
    .sin      (bus.mwdata),
    .load_en  (1'b0),
    .load_dat ('0),
    .q        (mem_addr)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_wdata_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (data_shift),
    .sin      (bus.mwdata),
    .load_en  (1'b0),
    .load_dat ('0),
    .q        (mem_wdata)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_rdata_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (rd_shift),
    .sin      (1'b0),
    .load_en  (rd_load),
    .load_dat (mem_rdata),
    .q        (rd_q)
  );

  // Only the LSB leaves the port; the upper bits just walk down toward it.
  assign rd_unused = ^rd_q[DATA_WIDTH-1:1];

`ifdef SLAVE_PORT_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perr <= 1'b0;
      rpar <= 1'b0;
    end else begin
      perr <= perr_set;
      if (rd_load) begin
        rpar <= ^mem_rdata;
      end
    end
  end

  assign send_bit = (cnt == RSEND_LAST) ? rpar : rd_q[0];
`else
  assign send_bit = rd_q[0];
`endif

  assign bus.sready = sready;
  assign bus.svalid = svalid;
  assign bus.srdata = svalid & send_bit;

endmodule

// File: tb/tb_slave_bus_port.sv
// Scoreboard bench for slave_bus_port: drivers push expected memory/serial events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_slave_bus_port;

  localparam int AW = 12;
  localparam int DW = 32;
`ifdef SLAVE_PORT_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          mem_wen;
  logic          mem_ren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] rd_word;
`ifdef SLAVE_PORT_PARITY_EN
  logic          perr;
`endif

  slave_bus_port_if bus ();

  slave_bus_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef SLAVE_PORT_PARITY_EN
    ,
    .perr      (perr)
`endif
  );

  // Memory model drives data only during the read strobe.
  assign mem_rdata = mem_ren ? rd_word : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  int   wen_seen = 0;
  int   ren_seen = 0;
  int   perr_seen = 0;
  int   wen_total = 0;
  int   ren_total = 0;
  int   perr_total = 0;
  exp_t wq[$];
  exp_t renq[$];
  logic rbq[$];
  int   pq[$];
  exp_t mon_e;
  logic mon_b;
  int   mon_p;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wen) begin
        wen_seen++;
        if (wq.size() == 0) begin
          chk(1'b0, "wen_unexpected", 64'(cyc), 64'(0));
        end else begin
          mon_e = wq.pop_front();
          chk(cyc == mon_e.cyc, "wen_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk(mem_addr == mon_e.addr[AW-1:0], "wen_addr", 64'(mem_addr), 64'(mon_e.addr));
          chk(mem_wdata == mon_e.data, "wen_wdata", 64'(mem_wdata), 64'(mon_e.data));
        end
      end
      if (mem_ren) begin
        ren_seen++;
        if (renq.size() == 0) begin
          chk(1'b0, "ren_unexpected", 64'(cyc), 64'(0));
        end else begin
          mon_e = renq.pop_front();
          chk(cyc == mon_e.cyc, "ren_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk(mem_addr == mon_e.addr[AW-1:0], "ren_addr", 64'(mem_addr), 64'(mon_e.addr));
        end
      end
      if (bus.svalid) begin
        if (rbq.size() == 0) begin
          chk(1'b0, "svalid_unexpected", 64'(cyc), 64'(0));
        end else begin
          mon_b = rbq.pop_front();
          chk(bus.srdata == mon_b, "srdata_bit", 64'(bus.srdata), 64'(mon_b));
        end
      end
`ifdef SLAVE_PORT_PARITY_EN
      if (perr) begin
        perr_seen++;
        if (pq.size() == 0) begin
          chk(1'b0, "perr_unexpected", 64'(cyc), 64'(0));
        end else begin
          mon_p = pq.pop_front();
          chk(cyc == mon_p, "perr_cycle", 64'(cyc), 64'(mon_p));
        end
      end
`endif
    end
  end

  task automatic put_bit(input logic b, input logic m);
    @(negedge clk);
    bus.mvalid = 1'b1;
    bus.mwdata = b;
    bus.mmode  = m;
  endtask

  // Stall cycles carry junk on mwdata/mmode so any illegal shift would show up.
  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.mvalid = 1'b0;
      bus.mwdata = 1'b1;
      bus.mmode  = 1'b1;
    end
  endtask

  task automatic wait_idle(input int exp, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    bus.mvalid = 1'b0;
    bus.mwdata = 1'b0;
    bus.mmode  = 1'b0;
    while (!bus.sready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(bus.sready && cyc == exp, nm, 64'(cyc), 64'(exp));
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input int sa, input int sd,
                          input int sl, input int abort_d, input bit bad_par);
    int   k;
    int   lat;
    exp_t e;
    k   = 0;
    lat = AW + DW + PAR + ((sa >= 0) ? sl : 0) + ((sd >= 0) ? sl : 0);
    for (int i = 0; i < AW; i++) begin
      put_bit(a[i], (i == 0) ? 1'b1 : 1'b0);
      if (i == 0) begin
        k = cyc;
        if (abort_d < 0) begin
          if (bad_par) begin
            pq.push_back(k + lat);
            perr_total++;
          end else begin
            e.cyc = k + lat; e.addr = 32'(a); e.data = d;
            wq.push_back(e);
            wen_total++;
          end
        end
      end
      if (i == sa) gap(sl);
    end
    for (int i = 0; i < DW; i++) begin
      put_bit(d[i], 1'b0);
      if (i == sd) gap(sl);
      if (i == abort_d) begin
        @(negedge clk);
        rst = 1'b1;
        bus.mvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk(bus.sready == 1'b1, "sready_after_rst", 64'(bus.sready), 64'(1));
        return;
      end
    end
`ifdef SLAVE_PORT_PARITY_EN
    put_bit((^d) ^ bad_par, 1'b0);
`endif
    wait_idle(bad_par ? k + lat : k + lat + 1, "sready_after_write");
  endtask

  task automatic do_read(input logic [11:0] a, input logic [31:0] w, input bit toggle);
    int   k;
    exp_t e;
    k = 0;
    rd_word = w;
    for (int i = 0; i < AW; i++) begin
      put_bit(a[i], (i == 0) ? 1'b0 : 1'b1);
      if (i == 0) begin
        k = cyc;
        e.cyc = k + AW; e.addr = 32'(a); e.data = w;
        renq.push_back(e);
        ren_total++;
        for (int j = 0; j < DW; j++) rbq.push_back(w[j]);
        if (PAR == 1) rbq.push_back(^w);
      end
    end
    if (toggle) begin
      for (int j = 0; j < DW + 1 + PAR; j++) begin
        @(negedge clk);
        bus.mvalid = j[0];
        bus.mwdata = 1'b1;
        bus.mmode  = 1'b1;
        chk(bus.sready == 1'b0, "sready_busy_rsend", 64'(bus.sready), 64'(0));
      end
    end
    wait_idle(k + AW + DW + PAR + 1, "sready_after_read");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    rd_word    = '0;
    bus.mvalid = 1'b0;
    bus.mwdata = 1'b0;
    bus.mmode  = 1'b0;
    repeat (3) @(negedge clk);
    chk(bus.sready == 1'b1, "rst_sready", 64'(bus.sready), 64'(1));
    chk(bus.svalid == 1'b0, "rst_svalid", 64'(bus.svalid), 64'(0));
    chk(bus.srdata == 1'b0, "rst_srdata", 64'(bus.srdata), 64'(0));
    chk(mem_wen == 1'b0, "rst_wen", 64'(mem_wen), 64'(0));
    chk(mem_ren == 1'b0, "rst_ren", 64'(mem_ren), 64'(0));
    chk(mem_addr == '0, "rst_addr", 64'(mem_addr), 64'(0));
    chk(mem_wdata == '0, "rst_wdata", 64'(mem_wdata), 64'(0));
`ifdef SLAVE_PORT_PARITY_EN
    chk(perr == 1'b0, "rst_perr", 64'(perr), 64'(0));
`endif
    rst = 1'b0;

    do_write(12'h0A5, 32'hDEADBEEF, -1, -1, 0, -1, 1'b0);
    do_read(12'h0A5, 32'hDEADBEEF, 1'b0);
    do_write(12'h0A5, 32'hDEADBEEF, 5, 20, 3, -1, 1'b0);
    do_write(12'h7FF, 32'hCAFEF00D, -1, -1, 0, 10, 1'b0);
    do_write(12'h001, 32'h12345678, -1, -1, 0, -1, 1'b0);
    do_read(12'h3C2, 32'h0F0F1234, 1'b1);
`ifdef SLAVE_PORT_PARITY_EN
    do_write(12'h010, 32'h00000001, -1, -1, 0, -1, 1'b1);
    do_write(12'h010, 32'h00000001, -1, -1, 0, -1, 1'b0);
`endif

    repeat (5) @(negedge clk);
    chk(wq.size() == 0, "wen_pending", 64'(wq.size()), 64'(0));
    chk(renq.size() == 0, "ren_pending", 64'(renq.size()), 64'(0));
    chk(rbq.size() == 0, "rbits_pending", 64'(rbq.size()), 64'(0));
    chk(pq.size() == 0, "perr_pending", 64'(pq.size()), 64'(0));
    chk(wen_seen == wen_total, "wen_count", 64'(wen_seen), 64'(wen_total));
    chk(ren_seen == ren_total, "ren_count", 64'(ren_seen), 64'(ren_total));
    chk(perr_seen == perr_total, "perr_count", 64'(perr_seen), 64'(perr_total));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slave_bus_port.md
Name: slave_bus_port

Overview:
Bus-side front end for a slave memory. It deserialises bit-serial bus transactions (mode, address, write data) and drives the memory's single-cycle wen/ren/addr/wdata interface. For reads it captures the memory's rdata and serialises it back onto the bus. It sits directly upstream of the slave memory, between the bus interconnect and the memory array.

Parameters:
ADDR_WIDTH, 12, local slave address bits received serially and driven on mem_addr
DATA_WIDTH, 32, data word width; matches the memory's wdata/rdata

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous, active-high reset
mvalid  in  1  master bit strobe; high = mwdata carries a valid serial bit this cycle
mwdata  in  1  serial address then write data, LSB first
mmode  in  1  transaction mode, sampled only with the first address bit: 1 = write, 0 = read
sready  out  1  high only in IDLE; slave can accept a new transaction
svalid  out  1  high for each cycle srdata carries a valid read bit
srdata  out  1  serial read data, LSB first
mem_wen  out  1  memory write enable, one-cycle pulse
mem_ren  out  1  memory read enable, one-cycle pulse
mem_addr  out  ADDR_WIDTH  memory address (address shift register)
mem_wdata  out  DATA_WIDTH  memory write data (data shift register)
mem_rdata  in  DATA_WIDTH  memory read data, valid combinationally while mem_ren = 1

Behaviour:
- Reset: synchronous and active-high. On the rst edge, state goes to IDLE, bit counter = 0 and shift registers clear.
- Output values after reset: sready = 1; svalid, srdata, mem_wen and mem_ren = 0; mem_addr and mem_wdata = 0.
- States and transitions:
  - IDLE: sready = 1. An edge with mvalid = 1 latches mmode, shifts in addr bit 0, sets counter = 1 and moves to ADDR.
  - ADDR: each edge with mvalid = 1 shifts in one address bit and increments the counter. When the edge consumes bit ADDR_WIDTH-1, the counter resets and the state moves to WDATA (write) or READ (read).
  - WDATA: shifts in DATA_WIDTH bits the same way. After the last bit, moves to WRITE.
  - WRITE: mem_wen = 1 for exactly one cycle, with mem_addr and mem_wdata stable. Then IDLE.
  - READ: mem_ren = 1 for exactly one cycle. mem_rdata is loaded into the output shift register at the end of that cycle. Then RSEND.
  - RSEND: svalid = 1 and srdata = shreg[0]; shift right once per cycle for DATA_WIDTH cycles. Then IDLE. There is no backpressure on read data.
- Timing, with the first address bit sampled at edge E0 (A = ADDR_WIDTH, D = DATA_WIDTH):
  - Write, continuous mvalid: last data bit at E(A+D-1); mem_wen high in the following cycle; memory writes at E(A+D); sready = 1 after E(A+D).
  - Read: mem_ren high in the cycle after E(A-1); rdata captured at E(A); svalid high for cycles E(A)..E(A+D); sready = 1 after E(A+D).
- Stalls: mvalid = 0 during ADDR/WDATA freezes the counter and shift registers. Gaps of any length are legal.
- Ignored inputs:
  - mvalid/mmode/mwdata are ignored in WRITE, READ and RSEND; a new transaction is only accepted in IDLE.
  - mmode is ignored after the first bit.
- Reset mid-transaction: the transaction is abandoned. No mem_wen or mem_ren pulse is produced and no partial read bits are sent.
- mem_addr/mem_wdata values are meaningful only while mem_wen or mem_ren = 1.

Optional Feature:
Macro SLAVE_PORT_PARITY_EN.
- When defined:
  - Write: one extra bit follows the last data bit — even parity over wdata, in a WPAR state.
  - Good write parity: WRITE proceeds with write latency +1 cycle.
  - Bad write parity: output perr (1 bit, reset 0) pulses high for one cycle, no mem_wen is issued, and the state returns to IDLE.
  - Read: RSEND sends DATA_WIDTH+1 bits; the final bit is even parity over the read word.
- When undefined: no perr port, no parity bits, timing exactly as above.

Decomposition:
- Shared package bus_pkg:
  - state enum (IDLE, ADDR, WDATA, WPAR, WRITE, READ, RSEND)
  - MODE_READ = 1'b0, MODE_WRITE = 1'b1
  - counter width = $clog2 of the larger of ADDR_WIDTH and DATA_WIDTH+1
- One natural sub-module: serial_shift_reg, parameterised WIDTH, with shift-in, parallel load and shift-out. It is instantiated for the address, write data and read data paths.

Test Plan:
1. Write, continuous mvalid, addr 0x0A5, data 0xDEADBEEF, default widths -> mem_wen high in exactly one cycle (after E43), mem_addr = 0x0A5, mem_wdata = 0xDEADBEEF; sready = 1 after E44.
2. Read, addr 0x0A5, mem_rdata = 0xDEADBEEF -> mem_ren one cycle after E11; svalid high for 32 cycles; srdata sequence starts 1,1,1,1,0,1,1,1 (0xEF, LSB first); sready = 1 afterwards.
3. Write with mvalid dropped for 3 cycles after addr bit 5 and for 3 cycles after data bit 20 -> same mem_addr/mem_wdata as case 1, mem_wen delayed by exactly 6 cycles.
4. rst asserted for one cycle after data bit 10 of a write -> no mem_wen ever; sready = 1 the next cycle; an immediately following write to 0x001 of 0x12345678 completes correctly.
5. mvalid toggled with mmode = 1 during RSEND -> ignored; sready stays 0 until all 32 read bits are sent; no mem_wen.
6. SLAVE_PORT_PARITY_EN defined, write 0x00000001 with parity bit 0 (wrong) -> perr pulses one cycle, no mem_wen, sready = 1 next cycle. With parity bit 1 -> mem_wen pulse and perr stays 0.
